// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : pipeline hold/flush controller with memory wait, I/O halt and
//             deferred branch flush. Optional macro: PIPE_CTRL_PERF_EN.
// Revision  : 1.0
// ============================================================================
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 3,
  parameter int WAIT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  branch_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  halt_req_i,
  input  logic                  enter_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [1:0]            state_o,
  output logic                  timeout_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [NUM_STAGES-1:0] c_mem_bit   = NUM_STAGES'(1) << MEM_STAGE;
  localparam logic [WAIT_W-1:0]     c_wait_last = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t                r_state, w_state_n;
  logic [WAIT_W-1:0]     r_wait_cnt, w_wait_cnt_n;
  logic                  r_pending;
  logic                  r_enter_q;
  logic                  r_timeout;
  logic [NUM_STAGES-1:0] w_req;
  logic [NUM_STAGES-1:0] w_therm_stall;
  logic [NUM_STAGES-1:0] w_therm_flush;
  logic                  w_halt_all;
  logic                  w_timeout_set;
  logic                  w_mem_wait;
  logic                  w_branch_any;

  // Once timed out, the memory wait path stays disabled until reset.
  assign w_mem_wait   = mem_req_i & ~mem_ready_i & ~r_timeout;
  assign w_branch_any = branch_i | r_pending;

  always_comb begin
    w_state_n     = r_state;
    w_wait_cnt_n  = '0;
    w_req         = stallreq_i;
    w_halt_all    = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt_req_i) begin
          w_halt_all = 1'b1;
          w_state_n  = ST_HALT;
        end else if (w_mem_wait) begin
          w_req     = stallreq_i | c_mem_bit;
          w_state_n = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        w_req = stallreq_i | c_mem_bit;
        if (mem_ready_i) begin
          w_state_n = ST_RUN;
        end else if (r_wait_cnt == c_wait_last) begin
          w_timeout_set = 1'b1;
          w_state_n     = ST_RUN;
        end else begin
          w_wait_cnt_n = r_wait_cnt + 1'b1;
        end
      end
      ST_HALT: begin
        w_halt_all = 1'b1;
        if (enter_i && !r_enter_q) w_state_n = ST_RUN;
      end
      default: w_state_n = ST_RUN;
    endcase
  end

  // Highest requesting index holds itself and everything upstream.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_thermo
    assign w_therm_stall[k] = |w_req[NUM_STAGES-1:k];
    if (k == 0) begin : g_first
      assign w_therm_flush[k] = 1'b0;
    end else begin : g_rest
      assign w_therm_flush[k] = w_therm_stall[k-1] & ~w_therm_stall[k];
    end
  end

  always_comb begin
    stall_o = '0;
    flush_o = '1;
    if (!rst) begin
      if (w_halt_all) begin
        stall_o = '1;
        flush_o = '0;
      end else begin
        stall_o    = w_therm_stall;
        flush_o    = w_therm_flush;
        flush_o[1] = w_therm_flush[1] | (w_branch_any & ~w_therm_stall[1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_pending  <= 1'b0;
      r_enter_q  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_wait_cnt <= w_wait_cnt_n;
      r_pending  <= w_branch_any & stall_o[1];
      r_enter_q  <= enter_i;
      r_timeout  <= r_timeout | w_timeout_set;
    end
  end

  assign state_o   = rst ? ST_RUN : r_state;
  assign timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl : vector-table bench for pipe_ctrl plus timeout/counter runs.
// Revision     : 1.0
// ============================================================================
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq_i;
  logic        branch_i, mem_req_i, mem_ready_i, halt_req_i, enter_i;
  logic [4:0]  stall_o, flush_o;
  logic [1:0]  state_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(5), .MEM_STAGE(3), .WAIT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_i  (stallreq_i),
    .branch_i    (branch_i),
    .mem_req_i   (mem_req_i),
    .mem_ready_i (mem_ready_i),
    .halt_req_i  (halt_req_i),
    .enter_i     (enter_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .state_o     (state_o),
    .timeout_o   (timeout_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic       r;
    logic [4:0] s;
    logic       b, mq, md, h, e;
    logic [4:0] es, ef;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [4:0] s, logic b, logic mq, logic md,
                              logic h, logic e, logic [4:0] es, logic [4:0] ef,
                              logic [1:0] est);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.mq = mq; v.md = md; v.h = h; v.e = e;
    v.es = es; v.ef = ef; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] s, input logic b, input logic mq,
                       input logic md, input logic h, input logic e);
    rst = r; stallreq_i = s; branch_i = b; mem_req_i = mq;
    mem_ready_i = md; halt_req_i = h; enter_i = e;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst s         b  mq md h  e   stall     flush     st
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    tbl.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 2'd0));
    tbl.push_back(mk(0, 5'b00101, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 2'd0));
    tbl.push_back(mk(0, 5'b10000, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 2'd0));
    tbl.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 2'd0));
    // memory wait of three cycles then ready
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd1));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd1));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 0, 0, 5'b01111, 5'b10000, 2'd1));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    // memory wait OR-ed with stage requests
    tbl.push_back(mk(0, 5'b00010, 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd0));
    tbl.push_back(mk(0, 5'b10000, 0, 1, 0, 0, 0, 5'b11111, 5'b00000, 2'd1));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 0, 0, 5'b01111, 5'b10000, 2'd1));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    // deferred branch flush
    tbl.push_back(mk(0, 5'b00010, 1, 0, 0, 0, 0, 5'b00011, 5'b00100, 2'd0));
    tbl.push_back(mk(0, 5'b00010, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00010, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 5'b00000, 5'b00010, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    // halt with enter already high, then a real edge
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 1, 5'b11111, 5'b00000, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 2'd0));
    // halt takes priority over a memory wait
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 1, 1, 5'b11111, 5'b00000, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 5'b11111, 5'b00000, 2'd2));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    // reset during HALT
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 0, 5'b11111, 5'b00000, 2'd0));
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));
    // reset mid-MEM_WAIT with a branch pending
    tbl.push_back(mk(0, 5'b00000, 1, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd1));
    tbl.push_back(mk(1, 5'b00000, 0, 1, 0, 0, 0, 5'b00000, 5'b11111, 2'd0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].mq, tbl[i].md, tbl[i].h, tbl[i].e);
      #4;
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(tbl[i].es));
      chk($sformatf("v%0d_flush", i), 32'(flush_o), 32'(tbl[i].ef));
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(tbl[i].est));
      if (i > 0) chk($sformatf("v%0d_timeout", i), 32'(timeout_o), 32'd0);
      next_cycle();
    end

    // Timeout: ready never arrives; memory path stays disabled afterwards.
    drive(0, 5'b00000, 0, 1, 0, 0, 0);
    #4;
    chk("to_entry_state", 32'(state_o), 32'd0);
    next_cycle();
    for (int n = 0; n < 15; n++) begin
      #4;
      chk($sformatf("to_wait%0d_state", n), 32'(state_o), 32'd1);
      chk($sformatf("to_wait%0d_flag", n), 32'(timeout_o), 32'd0);
      next_cycle();
    end
    for (int n = 0; n < 3; n++) begin
      #4;
      chk($sformatf("to_after%0d_state", n), 32'(state_o), 32'd0);
      chk($sformatf("to_after%0d_flag", n), 32'(timeout_o), 32'd1);
      chk($sformatf("to_after%0d_stall", n), 32'(stall_o), 32'd0);
      next_cycle();
    end
    drive(1, 5'b00000, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 5'b00000, 0, 0, 0, 0, 0);
    #4;
    chk("to_cleared", 32'(timeout_o), 32'd0);
    next_cycle();

    // Stall-cycle counter: seven held cycles, then a reset pulse.
    drive(1, 5'b00000, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 5'b00000, 0, 0, 0, 0, 0);
    #4;
    chk("cnt_reset", stall_cnt_o, 32'd0);
    next_cycle();
    for (int n = 0; n < 7; n++) begin
      drive(0, 5'b00001, 0, 0, 0, 0, 0);
      next_cycle();
    end
    drive(0, 5'b00000, 0, 0, 0, 0, 0);
    #4;
`ifdef PIPE_CTRL_PERF_EN
    chk("cnt_seven", stall_cnt_o, 32'd7);
`else
    chk("cnt_tied", stall_cnt_o, 32'd0);
`endif
    next_cycle();
    drive(1, 5'b00000, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 5'b00000, 0, 0, 0, 0, 0);
    #4;
    chk("cnt_after_rst", stall_cnt_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
